// File: rtl/clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// clk_freq_monitor
//   Counts rising edges of an asynchronous monitored signal over a fixed gate
//   window of the system clock. After each measured window it reports the edge
//   count and whether it fell inside the expected range or was zero. It also
//   tracks lock, which means a run of consecutive in-range windows.
//
//   The first window after enable is a priming window. It is counted and then
//   discarded, so that stale synchronizer history never reaches a result.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   en           in   measurement enable; low returns to IDLE
//   meas_in      in   monitored signal, asynchronous, must be slower than clk/4
//   count        out  [CNT_W] edge count of the last completed window
//   count_valid  out  one-cycle pulse when count/in_range/stuck update
//   in_range     out  last count within [EXP_MIN, EXP_MAX]
//   stuck        out  last count was zero
//   locked       out  LOCK_WINDOWS consecutive in-range windows seen
// -----------------------------------------------------------------------------
module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 1000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 495,
  parameter int EXP_MAX      = 505,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             meas_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             stuck,
  output logic             locked
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int RUN_W  = $clog2(LOCK_WINDOWS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    MEASURE
  } state_t;

  state_t state, state_next;

  logic              s1, s2, s3;
  logic              rise;
  logic              window_end;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic [31:0]       final_ext;
  logic              final_ok;
  logic [RUN_W-1:0]  good_run;
  logic [RUN_W-1:0]  run_next;

  // Three-flop chain. s1/s2 resolve metastability, and s3 holds the previous
  // value of s2 for edge detection.
  // NOTE: clocked state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign window_end = (state != IDLE) && (gate_cnt == GATE_LAST);

  // Saturating increment. On the window-end cycle this value is the final
  // count, so a rise on that cycle still belongs to the closing window.
  assign edge_next = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
  assign final_ext = 32'(edge_next);
  assign final_ok  = (final_ext >= 32'(EXP_MIN)) && (final_ext <= 32'(EXP_MAX));
  assign run_next  = (good_run == RUN_FULL) ? good_run : good_run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = PRIME;
      PRIME:   if (window_end) state_next = MEASURE;
      MEASURE: state_next = MEASURE;
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      good_run    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      stuck       <= 1'b0;
      locked      <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (!en) begin
        // Reported results hold. Lock history is lost because the source is
        // no longer being watched.
        gate_cnt <= '0;
        edge_cnt <= '0;
        good_run <= '0;
        locked   <= 1'b0;
      end else if (state == IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (window_end) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        if (state == MEASURE) begin
          count       <= edge_next;
          count_valid <= 1'b1;
          in_range    <= final_ok;
          stuck       <= (edge_next == '0);
          if (final_ok) begin
            good_run <= run_next;
            locked   <= (run_next == RUN_FULL);
          end else begin
            good_run <= '0;
            locked   <= 1'b0;
          end
        end
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_next;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_freq_monitor
//   Drives two monitors from the same stimulus. Both use a gate of 100 cycles,
//   an expected range of 24..26 and a lock run of 3. One has an 8-bit counter
//   and the other a 4-bit counter, which saturates at 15.
//
//   A background generator toggles meas_in every `half` cycles. Setting half
//   to 0 holds meas_in low. Setting half to -1 hands the pin to manual_lvl.
//
//   Period changes are applied exactly one synchronizer latency before a
//   window boundary, so every window sees a single pattern.
//
//   Expected window results are queued before each window and compared when
//   count_valid pulses.
// -----------------------------------------------------------------------------
module tb_clk_freq_monitor;

  localparam int G = 100;

  typedef struct {
    int   lo;
    int   hi;
    logic in_r;
    logic stk;
    logic lck;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  wire        meas_in;
  logic       gen_lvl;
  logic       manual_lvl;
  int         half;

  logic [7:0] count8;
  logic       cv8, inr8, stk8, lck8;
  logic [3:0] count4;
  logic       cv4, inr4, stk4, lck4;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  assign meas_in = (half < 0) ? manual_lvl : gen_lvl;

  clk_freq_monitor #(
    .GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(24), .EXP_MAX(26), .LOCK_WINDOWS(3)
  ) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .meas_in(meas_in),
    .count(count8), .count_valid(cv8), .in_range(inr8), .stuck(stk8), .locked(lck8)
  );

  clk_freq_monitor #(
    .GATE_CYCLES(G), .CNT_W(4), .EXP_MIN(24), .EXP_MAX(26), .LOCK_WINDOWS(3)
  ) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .meas_in(meas_in),
    .count(count4), .count_valid(cv4), .in_range(inr4), .stuck(stk4), .locked(lck4)
  );

  initial begin
    int ph;
    gen_lvl = 1'b0;
    ph      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (half <= 0) begin
        gen_lvl = 1'b0;
        ph      = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ph      = 0;
          gen_lvl = ~gen_lvl;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_total++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: got %0d, want %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic push(input int lo, input int hi, input logic in_r, input logic stk,
                      input logic lck);
    exp_t e;
    e.lo   = lo;
    e.hi   = hi;
    e.in_r = in_r;
    e.stk  = stk;
    e.lck  = lck;
    sb.push_back(e);
  endtask

  // Waits for count_valid, with a bounded budget, and scores both monitors.
  // On return we are at the negedge just after the window-end clock edge.
  task automatic wait_valid(input string tag, output int n);
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!cv8 && n < 3 * G);
    check({tag, " valid8"}, 32'(cv8), 32'd1);
    check({tag, " valid4"}, 32'(cv4), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_range({tag, " count8"}, int'(count8), e.lo, e.hi);
    check({tag, " in_range8"}, 32'(inr8), 32'(e.in_r));
    check({tag, " stuck8"},    32'(stk8), 32'(e.stk));
    check({tag, " locked8"},   32'(lck8), 32'(e.lck));
    check_range({tag, " count4"}, int'(count4), (e.lo > 15) ? 15 : e.lo,
                (e.hi > 15) ? 15 : e.hi);
    check({tag, " in_range4"}, 32'(inr4), 32'd0);
    check({tag, " stuck4"},    32'(stk4), 32'(e.stk));
    check({tag, " locked4"},   32'(lck4), 32'd0);
  endtask

  // Called right after a count_valid. Switches the pin pattern so that the
  // new pattern starts with the first edge counted in the window after next.
  task automatic retime_at_boundary(input int h);
    @(posedge clk);
    @(negedge clk);
    check("pulse_width", 32'(cv8), 32'd0);
    repeat (G - 4) @(posedge clk);
    @(negedge clk);
    if (h < 0) manual_lvl = gen_lvl;
    half = h;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " count8"},  32'(count8), 32'd0);
    check({tag, " valid8"},  32'(cv8),    32'd0);
    check({tag, " in_rng8"}, 32'(inr8),   32'd0);
    check({tag, " stuck8"},  32'(stk8),   32'd0);
    check({tag, " lock8"},   32'(lck8),   32'd0);
    check({tag, " count4"},  32'(count4), 32'd0);
    check({tag, " lock4"},   32'(lck4),   32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    rst        = 1'b1;
    en         = 1'b0;
    half       = 2;
    manual_lvl = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_no_valid", 32'(cv8), 32'd0);

    // Period 4: 25 edges per window, lock on the third result
    en = 1'b1;
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w1", n);
    check("first_latency", 32'(n), 32'(2 * G + 1));
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w2", n);
    check("window_period", 32'(n), 32'(G));
    retime_at_boundary(3);
    push(25, 25, 1'b1, 1'b0, 1'b1);
    wait_valid("w3", n);

    // One window at period 6 drops lock; period 4 relocks after 3 windows
    retime_at_boundary(2);
    push(16, 17, 1'b0, 1'b0, 1'b0);
    wait_valid("w4_slow", n);
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w5", n);
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w6", n);
    retime_at_boundary(0);
    push(25, 25, 1'b1, 1'b0, 1'b1);
    wait_valid("w7_relock", n);

    // Pin held low: stuck, never locked
    push(0, 0, 1'b0, 1'b1, 1'b0);
    wait_valid("w8_stuck", n);
    retime_at_boundary(2);
    push(0, 0, 1'b0, 1'b1, 1'b0);
    wait_valid("w9_stuck", n);
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w10", n);
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w11", n);
    push(25, 25, 1'b1, 1'b0, 1'b1);
    wait_valid("w12_lock", n);

    // en dropped mid-window: lock clears next cycle, results hold, no pulses
    repeat (50) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("endrop locked8", 32'(lck8),   32'd0);
    check("endrop valid8",  32'(cv8),    32'd0);
    check("endrop count8",  32'(count8), 32'd25);
    check("endrop in_rng8", 32'(inr8),   32'd1);
    check("endrop count4",  32'(count4), 32'd15);
    pulses = 0;
    repeat (3 * G) begin
      @(posedge clk);
      @(negedge clk);
      if (cv8) pulses++;
    end
    check("endrop pulses", 32'(pulses), 32'd0);
    en = 1'b1;
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w13_reen", n);
    check("reen_latency", 32'(n), 32'(2 * G + 1));

    // Reset at gate_cnt 50 of a MEASURE window
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w14_postrst", n);
    check("rst_latency", 32'(n), 32'(2 * G + 1));

    // Manual edges at the window boundaries
    retime_at_boundary(-1);
    push(25, 25, 1'b1, 1'b0, 1'b0);
    wait_valid("w15", n);
    manual_lvl = 1'b0;
    repeat (G - 3) @(posedge clk);
    @(negedge clk);
    manual_lvl = 1'b1;      // rise lands on the gate_cnt==99 cycle
    push(1, 1, 1'b0, 1'b0, 1'b0);
    wait_valid("w16_lastcyc", n);
    repeat (10) @(posedge clk);
    @(negedge clk);
    manual_lvl = 1'b0;
    repeat (G - 12) @(posedge clk);
    @(negedge clk);
    manual_lvl = 1'b1;      // one cycle later: first cycle of the next window
    push(0, 0, 1'b0, 1'b1, 1'b0);
    wait_valid("w17_before", n);
    push(1, 1, 1'b0, 1'b0, 1'b0);
    wait_valid("w18_after", n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
